// File: rtl/mult_err_pkg.sv
// Shared types and default widths for the multiplier error monitor.
package mult_err_pkg;
  localparam int DEF_W        = 16;
  localparam int DEF_WIN_LOG2 = 10;
  localparam int DIFF_W       = 2*DEF_W + 1;
  localparam int CNT_W        = DEF_WIN_LOG2 + 1;
  localparam int ACC_W        = 2*DEF_W + DEF_WIN_LOG2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [ACC_W-1:0]   sum;
    logic [2*DEF_W-1:0] max;
    logic [CNT_W-1:0]   nz;
    logic [CNT_W-1:0]   under;
    logic [CNT_W-1:0]   cnt;
  } res_t;
endpackage

// File: rtl/mult_err_if.sv
// Sample input, window result and control signals of the error monitor.
// res handshake: a result transfers on a rising edge where res_valid && res_ready;
// res_* stay stable while res_valid is high; the sample input has no backpressure.
interface mult_err_if #(
  parameter int W        = mult_err_pkg::DEF_W,
  parameter int WIN_LOG2 = mult_err_pkg::DEF_WIN_LOG2
);
  import mult_err_pkg::*;

  logic                    clear;
  logic                    flush;
  logic                    in_valid;
  logic [W-1:0]            in_x;
  logic [W-1:0]            in_y;
  logic [2*W-1:0]          in_p;
  logic                    res_valid;
  logic                    res_ready;
  logic [2*W+WIN_LOG2-1:0] res_sum;
  logic [2*W-1:0]          res_max;
  logic [WIN_LOG2:0]       res_nz;
  logic [WIN_LOG2:0]       res_under;
  logic [WIN_LOG2:0]       res_cnt;
  logic                    res_overrun;
  state_t                  fsm_state;

  modport master (
    output clear, flush, in_valid, in_x, in_y, in_p, res_ready,
    input  res_valid, res_sum, res_max, res_nz, res_under, res_cnt, res_overrun, fsm_state
  );

  modport slave (
    input  clear, flush, in_valid, in_x, in_y, in_p, res_ready,
    output res_valid, res_sum, res_max, res_nz, res_under, res_cnt, res_overrun, fsm_state
  );
endinterface

// File: rtl/mult_err_diff.sv
// Stages S1/S2: exact product, signed error distance, magnitude and error flags.
module mult_err_diff import mult_err_pkg::*; #(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           in_valid,
  input  logic           in_tag,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  input  logic [2*W-1:0] in_p,
  output logic           s1_valid,
  output logic           s1_tag,
  output logic           s2_valid,
  output logic           s2_tag,
  output logic [2*W-1:0] s2_abs,
  output logic           s2_nz,
  output logic           s2_under
);
  localparam int D_W = 2*W + 1;

  logic [2*W-1:0] s1_exact;
  logic [2*W-1:0] s1_p;
  logic [D_W-1:0] diff;
  logic [2*W-1:0] abs_d;

  // diff = exact - p; a set sign bit means the approximation over-estimates
  assign diff  = {1'b0, s1_exact} - {1'b0, s1_p};
  assign abs_d = diff[D_W-1] ? (s1_p - s1_exact) : (s1_exact - s1_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_tag   <= 1'b0;
      s1_exact <= '0;
      s1_p     <= '0;
      s2_valid <= 1'b0;
      s2_tag   <= 1'b0;
      s2_abs   <= '0;
      s2_nz    <= 1'b0;
      s2_under <= 1'b0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s1_tag   <= 1'b0;
      s1_exact <= '0;
      s1_p     <= '0;
      s2_valid <= 1'b0;
      s2_tag   <= 1'b0;
      s2_abs   <= '0;
      s2_nz    <= 1'b0;
      s2_under <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_tag   <= in_tag;
      if (in_valid) begin
        s1_exact <= {{W{1'b0}}, in_x} * {{W{1'b0}}, in_y};
        s1_p     <= in_p;
      end
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
      if (s1_valid) begin
        s2_abs   <= abs_d;
        s2_nz    <= |diff;
        s2_under <= !diff[D_W-1] && (|diff);
      end
    end
  end
endmodule

// File: rtl/mult_err_monitor.sv
// Windowed error-distance statistics for an approximate multiplier: S3 accumulators,
// window FSM (IDLE/RUN/DRAIN), result registers and the result handshake.
module mult_err_monitor import mult_err_pkg::*; #(
  parameter int W        = DEF_W,
  parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
  input logic       clk,
  input logic       rst_n,
  mult_err_if.slave bus
);
  localparam int A_W = 2*W + WIN_LOG2;
  localparam int C_W = WIN_LOG2 + 1;
  localparam logic [C_W-1:0] LAST = C_W'((1 << WIN_LOG2) - 1);

  state_t         state;
  logic           cur_tag;
  logic           acc_tag;
  logic [A_W-1:0] acc_sum;
  logic [2*W-1:0] acc_max;
  logic [C_W-1:0] acc_nz;
  logic [C_W-1:0] acc_under;
  logic [C_W-1:0] acc_cnt;

  logic           res_valid;
  logic [A_W-1:0] res_sum;
  logic [2*W-1:0] res_max;
  logic [C_W-1:0] res_nz;
  logic [C_W-1:0] res_under;
  logic [C_W-1:0] res_cnt;
  logic           res_overrun;

  logic           s1_valid, s1_tag, s2_valid, s2_tag, s2_nz, s2_under;
  logic [2*W-1:0] s2_abs;
  logic           in_tag, s1_in_win, s2_in_win, s2_next;
  logic           full_close, drain_close, close, flush_take, res_load;
  logic [A_W-1:0] fin_sum;
  logic [2*W-1:0] fin_max;
  logic [C_W-1:0] fin_nz, fin_under, fin_cnt;

  mult_err_diff #(.W(W)) u_diff (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (bus.clear),
    .in_valid (bus.in_valid),
    .in_tag   (in_tag),
    .in_x     (bus.in_x),
    .in_y     (bus.in_y),
    .in_p     (bus.in_p),
    .s1_valid (s1_valid),
    .s1_tag   (s1_tag),
    .s2_valid (s2_valid),
    .s2_tag   (s2_tag),
    .s2_abs   (s2_abs),
    .s2_nz    (s2_nz),
    .s2_under (s2_under)
  );

  // acc_tag names the window being accumulated; cur_tag is stamped on new samples
  assign s1_in_win   = s1_valid && (s1_tag == acc_tag);
  assign s2_in_win   = s2_valid && (s2_tag == acc_tag);
  assign s2_next     = s2_valid && (s2_tag != acc_tag);
  assign full_close  = s2_in_win && (acc_cnt == LAST);
  assign drain_close = (state == DRAIN) && !s1_in_win;
  assign close       = full_close || drain_close;
  assign flush_take  = bus.flush && (state == RUN) && !full_close &&
                       ((acc_cnt != '0) || s1_in_win || s2_in_win);
  assign in_tag      = flush_take ? ~cur_tag : cur_tag;
  assign res_load    = close && (!res_valid || bus.res_ready);

  always_comb begin
    fin_sum   = acc_sum;
    fin_max   = acc_max;
    fin_nz    = acc_nz;
    fin_under = acc_under;
    fin_cnt   = acc_cnt;
    if (s2_in_win) begin
      fin_sum   = acc_sum + A_W'(s2_abs);
      fin_nz    = acc_nz + C_W'(s2_nz);
      fin_under = acc_under + C_W'(s2_under);
      fin_cnt   = acc_cnt + 1'b1;
      if (s2_abs > acc_max) fin_max = s2_abs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_tag     <= 1'b0;
      acc_tag     <= 1'b0;
      acc_sum     <= '0;
      acc_max     <= '0;
      acc_nz      <= '0;
      acc_under   <= '0;
      acc_cnt     <= '0;
      res_valid   <= 1'b0;
      res_sum     <= '0;
      res_max     <= '0;
      res_nz      <= '0;
      res_under   <= '0;
      res_cnt     <= '0;
      res_overrun <= 1'b0;
    end else if (bus.clear) begin
      state       <= IDLE;
      cur_tag     <= 1'b0;
      acc_tag     <= 1'b0;
      acc_sum     <= '0;
      acc_max     <= '0;
      acc_nz      <= '0;
      acc_under   <= '0;
      acc_cnt     <= '0;
      res_valid   <= 1'b0;
      res_sum     <= '0;
      res_max     <= '0;
      res_nz      <= '0;
      res_under   <= '0;
      res_cnt     <= '0;
      res_overrun <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (bus.in_valid) state <= RUN;
        RUN:     if (flush_take) state <= DRAIN;
        DRAIN:   if (drain_close) state <= RUN;
        default: state <= IDLE;
      endcase
      if (flush_take) cur_tag <= ~cur_tag;
      if (drain_close) acc_tag <= cur_tag;

      // A closing window restarts empty, or seeded by a next-window sample already in S2
      if (close) begin
        acc_sum   <= s2_next ? A_W'(s2_abs) : '0;
        acc_max   <= s2_next ? s2_abs : '0;
        acc_nz    <= s2_next ? C_W'(s2_nz) : '0;
        acc_under <= s2_next ? C_W'(s2_under) : '0;
        acc_cnt   <= s2_next ? C_W'(1) : '0;
      end else begin
        acc_sum   <= fin_sum;
        acc_max   <= fin_max;
        acc_nz    <= fin_nz;
        acc_under <= fin_under;
        acc_cnt   <= fin_cnt;
      end

      if (res_load) begin
        res_valid <= 1'b1;
        res_sum   <= fin_sum;
        res_max   <= fin_max;
        res_nz    <= fin_nz;
        res_under <= fin_under;
        res_cnt   <= fin_cnt;
      end else if (res_valid && bus.res_ready) begin
        res_valid <= 1'b0;
      end
      if (close && res_valid && !bus.res_ready) res_overrun <= 1'b1;
    end
  end

  assign bus.res_valid   = res_valid;
  assign bus.res_sum     = res_sum;
  assign bus.res_max     = res_max;
  assign bus.res_nz      = res_nz;
  assign bus.res_under   = res_under;
  assign bus.res_cnt     = res_cnt;
  assign bus.res_overrun = res_overrun;
  assign bus.fsm_state   = state;
endmodule
